ula_serial_ctrl: RTL

- Bit-serial sequencer for the team's existing 1-bit ALU slice, `ula_overflow`.
- It computes a WIDTH-bit AND/OR/ADD/SUB/SLT/NOR by driving one slice instance LSB-first, one bit per clock.
- It owns the carry flop, the result shift register and the flag generation.
- It sits between the instruction-decode stage (start/done handshake) and the register-file write-back.

---
 rtl/ula_pkg.sv | 33 +++
 rtl/ula_serial_ctrl_if.sv | 42 ++++
 rtl/ula_ctl_decode.sv | 32 +++
 rtl/ula_overflow.sv | 36 +++
 rtl/ula_serial_ctrl.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/ula_pkg.sv
// ula_pkg: shared definitions for the bit-serial ALU sequencer.
//   - alu_ctl operation codes (ALU_AND .. ALU_NOR)
//   - sequencer state encoding (S_IDLE, S_RUN, S_FIN)
//   - decoded slice-control struct
package ula_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    // Slice op field: 00 AND, 01 OR, 10 SUM, 11 LESS
    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_SUM = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    typedef struct packed {
        logic       ainvert;
        logic       binvert;
        logic [1:0] op;
        logic       is_slt;
        logic       legal;
    } ctl_dec_t;

endpackage

// File: rtl/ula_serial_ctrl_if.sv
// ula_serial_ctrl_if: start/done handshake and result bus between the
// instruction-decode stage (master) and the serial ALU sequencer (slave).
//   start, alu_ctl, a, b          : request from decode
//   busy, done, result, flags     : response toward write-back
//   ovf_clr / ovf_sticky          : present only with ULA_OVF_STICKY_EN
interface ula_serial_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [3:0]       alu_ctl;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             carry_out;
    logic             overflow;
    logic             illegal;
`ifdef ULA_OVF_STICKY_EN
    logic             ovf_clr;
    logic             ovf_sticky;
`endif

    modport master (
        output start, alu_ctl, a, b,
`ifdef ULA_OVF_STICKY_EN
        output ovf_clr,
        input  ovf_sticky,
`endif
        input  busy, done, result, zero, carry_out, overflow, illegal
    );

    modport slave (
        input  start, alu_ctl, a, b,
`ifdef ULA_OVF_STICKY_EN
        input  ovf_clr,
        output ovf_sticky,
`endif
        output busy, done, result, zero, carry_out, overflow, illegal
    );
endinterface

// File: rtl/ula_ctl_decode.sv
// ula_ctl_decode: alu_ctl -> slice controls {ainvert, binvert, op, is_slt, legal}.
//   alu_ctl : 4-bit operation code
//   dec     : decoded controls; unsupported codes give legal=0, all else 0
module ula_ctl_decode
    import ula_pkg::*;
(
    input  logic [3:0] alu_ctl,
    output ctl_dec_t   dec
);
    always_comb begin
        dec = '0;
        unique case (alu_ctl)
            ALU_AND: begin dec.op = OP_AND; dec.legal = 1'b1; end
            ALU_OR:  begin dec.op = OP_OR;  dec.legal = 1'b1; end
            ALU_ADD: begin dec.op = OP_SUM; dec.legal = 1'b1; end
            ALU_SUB: begin dec.op = OP_SUM; dec.binvert = 1'b1; dec.legal = 1'b1; end
            ALU_SLT: begin
                dec.op      = OP_SUM;
                dec.binvert = 1'b1;
                dec.is_slt  = 1'b1;
                dec.legal   = 1'b1;
            end
            ALU_NOR: begin
                dec.op      = OP_AND;
                dec.ainvert = 1'b1;
                dec.binvert = 1'b1;
                dec.legal   = 1'b1;
            end
            default: dec = '0;
        endcase
    end
endmodule

// File: rtl/ula_overflow.sv
// ula_overflow: 1-bit ALU slice (existing block).
//   a, b      : operand bits         ainvert/binvert : operand inversion
//   cin, less : carry in, SLT input  op              : 00 AND 01 OR 10 SUM 11 LESS
//   result    : selected output      cout            : carry out
//   set       : raw sum bit          overflow        : cin ^ cout (valid on MSB)
module ula_overflow (
    input  logic       a,
    input  logic       b,
    input  logic       ainvert,
    input  logic       binvert,
    input  logic       cin,
    input  logic       less,
    input  logic [1:0] op,
    output logic       result,
    output logic       cout,
    output logic       set,
    output logic       overflow
);
    logic aa, bb, sum;

    assign aa       = ainvert ? ~a : a;
    assign bb       = binvert ? ~b : b;
    assign sum      = aa ^ bb ^ cin;
    assign cout     = (aa & bb) | (aa & cin) | (bb & cin);
    assign set      = sum;
    assign overflow = cin ^ cout;

    always_comb begin
        unique case (op)
            2'b00:   result = aa & bb;
            2'b01:   result = aa | bb;
            2'b10:   result = sum;
            default: result = less;
        endcase
    end
endmodule

// File: rtl/ula_serial_ctrl.sv
// ula_serial_ctrl: bit-serial sequencer driving one ula_overflow slice
// LSB-first, one bit per clock, for AND/OR/ADD/SUB/SLT/NOR.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus        : ula_serial_ctrl_if.slave (start/alu_ctl/a/b in,
//                busy/done/result/zero/carry_out/overflow/illegal out)
// Optional: define ULA_OVF_STICKY_EN to add ovf_clr / ovf_sticky.
// Timing: start accepted at edge k, done high after edge k+WIDTH+1.
module ula_serial_ctrl
    import ula_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    ula_serial_ctrl_if.slave bus
);
    state_t           state;
    logic [WIDTH-1:0] a_sh, b_sh, res_sh;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       ctl_q;
    logic             carry, msb_sum, ovf_q;

    logic             busy_q, done_q, zero_q, carry_q, ovf_out_q, illegal_q;
    logic [WIDTH-1:0] result_q;

    // One decoder: looks at the incoming code while idle (initial carry
    // needs binvert at acceptance) and at the latched code otherwise.
    logic [3:0] dec_in;
    ctl_dec_t   dec;

    assign dec_in = (state == S_IDLE) ? bus.alu_ctl : ctl_q;

    ula_ctl_decode u_dec (
        .alu_ctl (dec_in),
        .dec     (dec)
    );

    logic slice_res, slice_cout, slice_set, slice_ovf;

    ula_overflow u_slice (
        .a        (a_sh[0]),
        .b        (b_sh[0]),
        .ainvert  (dec.ainvert),
        .binvert  (dec.binvert),
        .cin      (carry),
        .less     (1'b0),
        .op       (dec.op),
        .result   (slice_res),
        .cout     (slice_cout),
        .set      (slice_set),
        .overflow (slice_ovf)
    );

    // Final values committed in FIN.
    logic [WIDTH-1:0] fin_result;
    logic             fin_carry, fin_ovf;

    always_comb begin
        fin_result = res_sh;
        fin_carry  = 1'b0;
        fin_ovf    = 1'b0;
        if (!dec.legal) begin
            fin_result = '0;
        end else if (dec.is_slt) begin
            // sign of a-b corrected for signed overflow
            fin_result    = '0;
            fin_result[0] = msb_sum ^ ovf_q;
            fin_carry     = carry;
        end else if (dec.op == OP_SUM) begin
            fin_carry = carry;
            fin_ovf   = ovf_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            a_sh      <= '0;
            b_sh      <= '0;
            res_sh    <= '0;
            cnt       <= '0;
            ctl_q     <= '0;
            carry     <= 1'b0;
            msb_sum   <= 1'b0;
            ovf_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            result_q  <= '0;
            zero_q    <= 1'b1;
            carry_q   <= 1'b0;
            ovf_out_q <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        a_sh   <= bus.a;
                        b_sh   <= bus.b;
                        ctl_q  <= bus.alu_ctl;
                        cnt    <= '0;
                        carry  <= dec.binvert;
                        busy_q <= 1'b1;
                        state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    res_sh <= {slice_res, res_sh[WIDTH-1:1]};
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    carry  <= slice_cout;
                    cnt    <= cnt + 1'b1;
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        msb_sum <= slice_set;
                        ovf_q   <= slice_ovf;
                        state   <= S_FIN;
                    end
                end
                S_FIN: begin
                    result_q  <= fin_result;
                    zero_q    <= (fin_result == '0);
                    carry_q   <= fin_carry;
                    ovf_out_q <= fin_ovf;
                    illegal_q <= ~dec.legal;
                    done_q    <= 1'b1;
                    busy_q    <= 1'b0;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;
    assign bus.carry_out = carry_q;
    assign bus.overflow  = ovf_out_q;
    assign bus.illegal   = illegal_q;

`ifdef ULA_OVF_STICKY_EN
    logic sticky_q;

    // A set in FIN takes priority over a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sticky_q <= 1'b0;
        else if (state == S_FIN && fin_ovf)
            sticky_q <= 1'b1;
        else if (bus.ovf_clr)
            sticky_q <= 1'b0;
    end

    assign bus.ovf_sticky = sticky_q;
`endif
endmodule
